// File: rtl/product_acc_pkg.sv
// Shared definitions for the multiplier datapath: default widths and the
// block-accumulator state encoding.
package product_acc_pkg;

  localparam int P_W_DEF   = 64;
  localparam int ACC_W_DEF = 80;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_acc_acc_add_ovf.sv
// Combinational signed adder: sign-extends a P_W product onto an ACC_W
// accumulator and flags two's-complement overflow of the wrapped sum.
module acc_add_ovf #(
  parameter int P_W   = 64,
  parameter int ACC_W = 80
) (
  input  logic [ACC_W-1:0] a,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);

  logic [ACC_W-1:0] p_ext;

  assign p_ext = {{(ACC_W-P_W){p[P_W-1]}}, p};
  assign sum   = a + p_ext;
  // Overflow: both operands share a sign and the result's sign differs.
  assign ovf   = (a[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != a[ACC_W-1]);

endmodule

// File: rtl/product_acc.sv
// Block accumulator: sums len signed products from the multiplier and holds
// the result until the consumer takes it, with a sticky overflow flag.
module product_acc
  import product_acc_pkg::*;
#(
  parameter int P_W   = P_W_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             p_valid,
  input  logic [P_W-1:0]   p_data,
  output logic             p_ready,
  output logic             acc_valid,
  output logic [ACC_W-1:0] acc_data,
  input  logic             acc_ready,
  output logic             ovf,
  output logic             busy
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [LEN_W-1:0] cnt;
  logic             add_ovf;

  acc_add_ovf #(
    .P_W   (P_W),
    .ACC_W (ACC_W)
  ) u_add (
    .a   (acc),
    .p   (p_data),
    .sum (sum),
    .ovf (add_ovf)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      ovf       <= 1'b0;
      p_ready   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= ACCUM;
            acc     <= '0;
            cnt     <= (len == '0) ? LEN_W'(1) : len;
            ovf     <= 1'b0;
            p_ready <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ACCUM: begin
          if (p_valid) begin
            acc <= sum;
            cnt <= cnt - LEN_W'(1);
            if (add_ovf) ovf <= 1'b1;
            // Last product: publish the sum directly so it is valid one cycle later.
            if (cnt == LEN_W'(1)) begin
              state     <= HOLD;
              p_ready   <= 1'b0;
              acc_valid <= 1'b1;
              acc_data  <= sum;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          p_ready   <= 1'b0;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
